// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and helpers for the data-memory responder.
//   WordW / BeW : data word width and byte-enable width
//   state_e     : responder FSM states (StInit, StIdle, StWait, StResp)
//   be_merge()  : byte-lane merge of a new word into an old word
package dmem_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned BeW   = 4;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StWait,
    StResp
  } state_e;

  // Lane i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic logic [WordW-1:0] be_merge(input logic [WordW-1:0] old_word,
                                                input logic [WordW-1:0] new_word,
                                                input logic [BeW-1:0]   be);
    logic [WordW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(BeW); i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with synchronous byte-lane write and
// combinational read of the addressed word.
//   clk_i   : clock
//   we_i    : write enable
//   idx_i   : word index
//   wdata_i : write data
//   be_i    : byte-lane enables for the write
//   rdata_o : current contents of word idx_i
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IdxW        = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  idx_i,
  input  logic [WordW-1:0] wdata_i,
  input  logic [BeW-1:0]   be_i,
  output logic [WordW-1:0] rdata_o
);

  logic [WordW-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= be_merge(mem_q[idx_i], wdata_i, be_i);
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data-memory responder.
// After reset the whole array is cleared (one word per cycle), then one
// load/store at a time is accepted, delayed LATENCY cycles, performed, and
// answered over a valid/ready response channel.
//   clk_i, rst_ni                     : clock, async active-low reset
//   req_valid_i / req_ready_o         : request handshake
//   req_we_i, req_addr_i, req_be_i,
//   req_wdata_i, req_pc_i             : request payload (pc only for logging)
//   resp_valid_o / resp_ready_i       : response handshake
//   resp_rdata_o, resp_err_o          : word after access, out-of-range flag
//   init_done_o                       : clear sweep finished
// Optional macro DMEM_WRITE_LOG_EN: print one line per committed store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [31:0]      req_addr_i,
  input  logic [BeW-1:0]   req_be_i,
  input  logic [WordW-1:0] req_wdata_i,
  input  logic [31:0]      req_pc_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WordW-1:0] resp_rdata_o,
  output logic             resp_err_o,
  output logic             init_done_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH_WORDS - 1);

  state_e           state_q;
  logic [IdxW-1:0]  init_idx_q;
  logic [CntW-1:0]  cnt_q;
  logic             we_q;
  logic [29:0]      word_addr_q;
  logic [BeW-1:0]   be_q;
  logic [WordW-1:0] wdata_q;
  logic [31:0]      pc_q;
  logic [WordW-1:0] resp_rdata_q;
  logic             resp_err_q;
  logic             init_done_q;

  logic             in_range;
  logic             commit;
  logic             ram_we;
  logic [IdxW-1:0]  ram_idx;
  logic [WordW-1:0] ram_wdata;
  logic [BeW-1:0]   ram_be;
  logic [WordW-1:0] ram_rdata;

  assign in_range = {2'b00, word_addr_q} < DEPTH_WORDS;
  assign commit   = (state_q == StWait) && (cnt_q == '0);

  // The init sweep and a committed store share the single RAM port.
  always_comb begin
    ram_we    = 1'b0;
    ram_idx   = word_addr_q[IdxW-1:0];
    ram_wdata = wdata_q;
    ram_be    = be_q;
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_idx   = init_idx_q;
      ram_wdata = '0;
      ram_be    = '1;
    end else if (commit && we_q && in_range) begin
      ram_we = 1'b1;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IdxW       (IdxW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .be_i   (ram_be),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StInit;
      init_idx_q   <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      word_addr_q  <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == LastIdx) begin
            state_q     <= StIdle;
            init_done_q <= 1'b1;
          end
        end
        StIdle: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            word_addr_q <= req_addr_i[31:2];
            be_q        <= req_be_i;
            wdata_q     <= req_wdata_i;
            pc_q        <= req_pc_i;
            cnt_q       <= CntW'(LATENCY - 1);
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
            if (!in_range) begin
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else begin
              resp_rdata_q <= we_q ? be_merge(ram_rdata, wdata_q, be_q) : ram_rdata;
              resp_err_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (resp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign init_done_o  = init_done_q;

  // Byte offset is irrelevant for word accesses.
  logic unused_addr_lo;
  assign unused_addr_lo = ^req_addr_i[1:0];

`ifdef DMEM_WRITE_LOG_EN
  always @(posedge clk_i) begin
    if (rst_ni && commit && we_q) begin
      if (!in_range) begin
        $display("ERR @%h: *%h <= %h", pc_q, {word_addr_q, 2'b00},
                 be_merge('0, wdata_q, be_q));
      end else if (be_q != '0) begin
        $display("@%h: *%h <= %h", pc_q, {word_addr_q, 2'b00},
                 be_merge(ram_rdata, wdata_q, be_q));
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (LATENCY 2 and 1, 16 words)
// share the request/response inputs; the idle one is held in reset and sel
// picks which outputs are observed.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2_n, rst1_n, sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [3:0]  req_be;

  logic        rr2, rv2, err2, id2;
  logic [31:0] rd2;
  logic        rr1, rv1, err1, id1;
  logic [31:0] rd1;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_init_done;
  logic [31:0] o_resp_rdata;

  assign o_req_ready  = sel ? rr1  : rr2;
  assign o_resp_valid = sel ? rv1  : rv2;
  assign o_resp_err   = sel ? err1 : err2;
  assign o_init_done  = sel ? id1  : id2;
  assign o_resp_rdata = sel ? rd1  : rd2;

  dmem_responder #(
    .DEPTH_WORDS(16),
    .LATENCY    (2)
  ) u_dut2 (
    .clk_i       (clk),
    .rst_ni      (rst2_n),
    .req_valid_i (req_valid),
    .req_ready_o (rr2),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .req_pc_i    (req_pc),
    .resp_valid_o(rv2),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(rd2),
    .resp_err_o  (err2),
    .init_done_o (id2)
  );

  dmem_responder #(
    .DEPTH_WORDS(16),
    .LATENCY    (1)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst1_n),
    .req_valid_i (req_valid),
    .req_ready_o (rr1),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .req_pc_i    (req_pc),
    .resp_valid_o(rv1),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(rd1),
    .resp_err_o  (err1),
    .init_done_o (id1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Called right after reset release (at a negedge); init_done must rise after 16 edges.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!o_init_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".init_cycles"}, 32'(n), 32'd16);
    check_eq({tag, ".req_ready"}, {31'b0, o_req_ready}, 32'd1);
  endtask

  // Called at a negedge with the observed DUT idle. During 'stall' RESP cycles
  // resp_ready stays low and a conflicting store is pulsed on the request port.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input int stall);
    int n;
    check_eq({tag, ".req_ready"}, {31'b0, o_req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_pc    = 32'h0000_1000 + addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    n = 0;
    while (!o_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".latency"}, 32'(n), 32'(lat));
    check_eq({tag, ".rdata"}, o_resp_rdata, exp_rdata);
    check_eq({tag, ".err"}, {31'b0, o_resp_err}, {31'b0, exp_err});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_be    = 4'hF;
      req_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq({tag, ".stall_valid"}, {31'b0, o_resp_valid}, 32'd1);
      check_eq({tag, ".stall_rdata"}, o_resp_rdata, exp_rdata);
      check_eq({tag, ".stall_err"}, {31'b0, o_resp_err}, {31'b0, exp_err});
      check_eq({tag, ".stall_req_ready"}, {31'b0, o_req_ready}, 32'd0);
    end
    req_we     = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq({tag, ".done_valid"}, {31'b0, o_resp_valid}, 32'd0);
    check_eq({tag, ".done_req_ready"}, {31'b0, o_req_ready}, 32'd1);
    check_eq({tag, ".held_rdata"}, o_resp_rdata, exp_rdata);
  endtask

  initial begin
    rst2_n = 1'b0; rst1_n = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0; req_be = 4'h0;
    repeat (3) @(negedge clk);

    check_eq("rst.req_ready", {31'b0, o_req_ready}, 32'd0);
    check_eq("rst.resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check_eq("rst.rdata", o_resp_rdata, 32'h0);
    check_eq("rst.err", {31'b0, o_resp_err}, 32'd0);
    check_eq("rst.init_done", {31'b0, o_init_done}, 32'd0);

    rst2_n = 1'b1;
    wait_init("init");

    do_txn("ld3c", 1'b0, 32'h3C, 4'h0, 32'h0, 32'h0000_0000, 1'b0, 2, 0);
    do_txn("st8", 1'b1, 32'h8, 4'hF, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 0);
    do_txn("ld8", 1'b0, 32'h8, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 2, 0);
    do_txn("st8_be5", 1'b1, 32'h8, 4'b0101, 32'hAABB_CCDD, 32'h12BB_56DD, 1'b0, 2, 0);
    do_txn("ld8_be5", 1'b0, 32'hB, 4'hF, 32'h0, 32'h12BB_56DD, 1'b0, 2, 0);
    do_txn("st8_be0", 1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 32'h12BB_56DD, 1'b0, 2, 0);
    do_txn("bp_ld8", 1'b0, 32'h8, 4'h0, 32'h0, 32'h12BB_56DD, 1'b0, 2, 5);
    do_txn("bp_ld8_after", 1'b0, 32'h8, 4'h0, 32'h0, 32'h12BB_56DD, 1'b0, 2, 0);
    do_txn("st40", 1'b1, 32'h40, 4'hF, 32'h5555_AAAA, 32'h0, 1'b1, 2, 0);
    do_txn("ld0_after_oor", 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 2, 0);
    do_txn("ld44_oor", 1'b0, 32'h44, 4'h0, 32'h0, 32'h0, 1'b1, 2, 0);

    // Abort a store in WAIT: reset lands before the commit edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_be = 4'hF;
    req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    check_eq("abort.resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check_eq("abort.init_done", {31'b0, o_init_done}, 32'd0);
    check_eq("abort.rdata", o_resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("abort.resp_valid_later", {31'b0, o_resp_valid}, 32'd0);
    rst2_n = 1'b1;
    wait_init("reinit");
    do_txn("ld4_after_abort", 1'b0, 32'h4, 4'h0, 32'h0, 32'h0, 1'b0, 2, 0);
    do_txn("ld8_after_abort", 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 2, 0);

    // LATENCY=1 instance.
    rst2_n = 1'b0;
    sel    = 1'b1;
    @(negedge clk);
    rst1_n = 1'b1;
    wait_init("l1_init");
    do_txn("l1_ld40", 1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0);
    do_txn("l1_st10", 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 0);
    do_txn("l1_st10_be8", 1'b1, 32'h10, 4'b1000, 32'h1100_0000, 32'h11FE_F00D, 1'b0, 1, 2);
    do_txn("l1_ld10", 1'b0, 32'h10, 4'h0, 32'h0, 32'h11FE_F00D, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
